pc_unit: RTL and testbench

//  - Parametrised program-counter unit; successor to the plain PC register in the single-cycle MIPS datapath.
//  - Holds the PC and selects the next PC by itself: sequential, branch, jump, register jump or return.
//  - Adds stall/hold, a programmable reset vector and a DEPTH-entry return-address stack (RAS) for jal/jr $ra.
//  - Sits between the control unit / branch comparator and instruction memory.

---
 rtl/mips_pc_pkg.sv | 11 +
 rtl/pc_unit_if.sv | 30 +++
 rtl/pc_ras.sv | 43 ++++
 rtl/pc_unit.sv | 92 +++++++++
 tb/tb_pc_unit.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pc_pkg.sv
// Shared constants for the program-counter unit: next-PC select codes and
// the word-alignment pattern.
package mips_pc_pkg;
  localparam logic [2:0] SEL_SEQ = 3'd0;
  localparam logic [2:0] SEL_BR  = 3'd1;
  localparam logic [2:0] SEL_J   = 3'd2;
  localparam logic [2:0] SEL_JR  = 3'd3;
  localparam logic [2:0] SEL_RET = 3'd4;

  localparam logic [1:0] ALIGN_ZERO = 2'b00;
endpackage

// File: rtl/pc_unit_if.sv
// Control-unit <-> PC-unit bundle. master drives the control flags,
// slave (the PC unit) returns the PC and RAS status.
interface pc_unit_if #(parameter int WIDTH = 32);
  logic             stall;
  logic             branch_taken;
  logic [15:0]      br_offset;
  logic             jump;
  logic [25:0]      jump_index;
  logic             jreg;
  logic [WIDTH-1:0] jreg_target;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_step;
  logic             ras_empty;
  logic             ras_full;
  logic             misalign_err;

  modport master (
    output stall, branch_taken, br_offset, jump, jump_index,
           jreg, jreg_target, call, ret,
    input  pc, pc_plus_step, ras_empty, ras_full, misalign_err
  );

  modport slave (
    input  stall, branch_taken, br_offset, jump, jump_index,
           jreg, jreg_target, call, ret,
    output pc, pc_plus_step, ras_empty, ras_full, misalign_err
  );
endinterface

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and an entry count.
// Pushing into a full stack silently overwrites the oldest entry.
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(RAS_DEPTH);

  logic [RAS_DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]                   top;
  logic [PW-1:0]                   top_nxt;
  logic [PW:0]                     cnt;

  assign top_nxt  = top + 1'b1;
  assign top_data = mem[top];
  assign empty    = (cnt == '0);
  assign full     = (cnt == (PW+1)'(RAS_DEPTH));

  // pop outranks push; the pointer wraps so a full push lands on the oldest slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem <= '0;
      top <= '0;
      cnt <= '0;
    end else if (pop && !empty) begin
      top <= top - 1'b1;
      cnt <= cnt - 1'b1;
    end else if (push) begin
      mem[top_nxt] <= push_data;
      top          <= top_nxt;
      if (!full) cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC select (seq/branch/jump/jr/return)
// and return-address stack for jal / jr $ra.
module pc_unit
  import mips_pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               STEP      = 4,
  parameter int               RAS_DEPTH = 4
) (
  input logic       clk,
  input logic       reset_n,
  pc_unit_if.slave  bus
);
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pps;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] j_tgt;
  logic [WIDTH-1:0] tgt;
  logic [WIDTH-1:0] ras_top;
  logic signed [WIDTH-1:0] br_sx;
  logic [27:0]      j_low;
  logic [2:0]       sel;
  logic             ras_empty, ras_full;
  logic             ras_push, ras_pop;
  logic             err_q;
  logic             misaligned;

  assign pps    = pc_q + WIDTH'(STEP);
  assign br_sx  = WIDTH'($signed(bus.br_offset));
  assign br_tgt = pps + (br_sx << 2);
  assign j_low  = {bus.jump_index, ALIGN_ZERO};

  // upper PC bits come from the delay-slot address; narrow PCs just truncate
  if (WIDTH > 28) begin : g_jhi
    assign j_tgt = {pps[WIDTH-1:28], j_low};
  end else begin : g_jlo
    assign j_tgt = j_low[WIDTH-1:0];
  end

  always_comb begin
    sel = SEL_SEQ;
    if (bus.ret && !ras_empty)   sel = SEL_RET;
    else if (bus.jreg || bus.ret) sel = SEL_JR;
    else if (bus.jump)            sel = SEL_J;
    else if (bus.branch_taken)    sel = SEL_BR;
  end

  always_comb begin
    tgt = pps;
    case (sel)
      SEL_RET: tgt = ras_top;
      SEL_JR:  tgt = bus.jreg_target;
      SEL_J:   tgt = j_tgt;
      SEL_BR:  tgt = br_tgt;
      default: tgt = pps;
    endcase
  end

  assign misaligned = (tgt[1:0] != ALIGN_ZERO);

  // a simultaneous ret drops the push even when the stack is empty
  assign ras_push = !bus.stall && bus.call && !bus.ret;
  assign ras_pop  = !bus.stall && bus.ret && !ras_empty;

  pc_ras #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pps),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= RESET_VEC;
      err_q <= 1'b0;
    end else if (!bus.stall) begin
      pc_q <= {tgt[WIDTH-1:2], ALIGN_ZERO};
      if (misaligned) err_q <= 1'b1;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.pc_plus_step = pps;
  assign bus.ras_empty    = ras_empty;
  assign bus.ras_full     = ras_full;
  assign bus.misalign_err = err_q;
endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random control traffic, all
// checked against a queue-based behavioural model of PC and return stack.
module tb_pc_unit;
  localparam logic [31:0] RV = 32'h0040_0000;

  logic clk = 1'b0;
  logic reset_n;
  int   n_chk = 0;
  int   n_err = 0;

  logic [31:0] m_pc;
  logic        m_err;
  logic [31:0] m_ras[$];

  always #5 clk = ~clk;

  pc_unit_if #(.WIDTH(32)) bus ();

  pc_unit #(.WIDTH(32), .RESET_VEC(RV), .STEP(4), .RAS_DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    bus.stall = 0; bus.branch_taken = 0; bus.br_offset = '0; bus.jump = 0;
    bus.jump_index = '0; bus.jreg = 0; bus.jreg_target = '0; bus.call = 0; bus.ret = 0;
  endtask

  task automatic mreset();
    m_pc = RV; m_err = 0; m_ras.delete();
  endtask

  // next-state rules written straight from the behavioural description
  task automatic model_step();
    logic [31:0] pps, t;
    if (bus.stall) return;
    pps = m_pc + 32'd4;
    if (bus.ret && m_ras.size() > 0) t = m_ras.pop_back();
    else if (bus.jreg || bus.ret)    t = bus.jreg_target;
    else if (bus.jump)               t = {pps[31:28], bus.jump_index, 2'b00};
    else if (bus.branch_taken)       t = pps + 32'(int'($signed(bus.br_offset)) * 4);
    else                             t = pps;
    if (bus.call && !bus.ret) begin
      m_ras.push_back(pps);
      if (m_ras.size() > 4) void'(m_ras.pop_front());
    end
    if (t % 4 != 0) begin
      m_err = 1;
      t = t - (t % 4);
    end
    m_pc = t;
  endtask

  task automatic check_all();
    chk("pc",    bus.pc, m_pc);
    chk("pps",   bus.pc_plus_step, m_pc + 32'd4);
    chk("empty", 32'(bus.ras_empty), 32'(m_ras.size() == 0));
    chk("full",  32'(bus.ras_full),  32'(m_ras.size() == 4));
    chk("err",   32'(bus.misalign_err), 32'(m_err));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // reset asserted between edges must show up without waiting for a clock
  task automatic do_reset();
    #2 reset_n = 0;
    #1;
    chk("async_rst_pc",  bus.pc, RV);
    chk("async_rst_err", 32'(bus.misalign_err), 32'd0);
    mreset();
    #1 reset_n = 1;
  endtask

  task automatic set_pc(input logic [31:0] a);
    clr(); bus.jreg = 1; bus.jreg_target = a; step(); clr();
  endtask

  initial begin
    clr();
    reset_n = 0;
    mreset();
    #12 reset_n = 1;
    check_all();
    chk("rst_pc", bus.pc, RV);

    // 1: free-running, then mid-cycle reset and free-running again
    step(); step(); step();
    chk("seq3", bus.pc, 32'h0040_000C);
    step();
    do_reset();
    step(); chk("seq_a", bus.pc, 32'h0040_0004);
    step(); chk("seq_b", bus.pc, 32'h0040_0008);
    step(); chk("seq_c", bus.pc, 32'h0040_000C);

    // 2: branches both directions
    set_pc(32'h100);
    bus.branch_taken = 1; bus.br_offset = 16'hFFFE; step();
    chk("br_back", bus.pc, 32'h0FC);
    set_pc(32'h100);
    bus.branch_taken = 1; bus.br_offset = 16'h0003; step();
    chk("br_fwd", bus.pc, 32'h110);

    // 3: absolute jump, misaligned register jump
    set_pc(32'h1000_0000);
    bus.jump = 1; bus.jump_index = 26'h000_0040; step();
    chk("jump", bus.pc, 32'h1000_0100);
    clr(); bus.jreg = 1; bus.jreg_target = 32'h203; step();
    chk("jr_align", bus.pc, 32'h200);
    chk("mis_set", 32'(bus.misalign_err), 32'd1);
    clr(); step(); step();
    chk("mis_sticky", 32'(bus.misalign_err), 32'd1);
    do_reset();

    // 4: call/return, then overflow the stack and underflow it
    set_pc(32'h100);
    bus.call = 1; bus.jump = 1; bus.jump_index = 26'h100; step();
    clr(); bus.ret = 1; step();
    chk("ret_pc", bus.pc, 32'h104);
    chk("ret_empty", 32'(bus.ras_empty), 32'd1);
    for (int k = 0; k < 5; k++) begin
      clr(); bus.call = 1; bus.jump = 1; bus.jump_index = 26'(32'h1000 + k * 32'h40); step();
    end
    for (int k = 0; k < 5; k++) begin
      clr(); bus.ret = 1; bus.jreg_target = 32'h0BAD_0000; step();
    end
    chk("underflow_pc", bus.pc, 32'h0BAD_0000);

    // 5: stall holds everything
    set_pc(32'h300);
    for (int k = 0; k < 3; k++) begin
      clr(); bus.stall = 1; bus.jump = 1; bus.call = 1; bus.jump_index = 26'h80; step();
      chk("stall_pc", bus.pc, 32'h300);
      chk("stall_empty", 32'(bus.ras_empty), 32'd1);
    end
    bus.stall = 0; bus.call = 0; step();
    chk("unstall_j", bus.pc, 32'h0000_0200);

    // 6: wrap, then call+ret collision
    set_pc(32'hFFFF_FFFC);
    step();
    chk("wrap", bus.pc, 32'h0);
    clr(); bus.call = 1; bus.jump = 1; bus.jump_index = 26'h40; step();
    clr(); bus.call = 1; bus.ret = 1; bus.jreg_target = 32'h500; step();
    chk("callret_pc", bus.pc, 32'h4);
    chk("callret_empty", 32'(bus.ras_empty), 32'd1);

    // random control traffic
    for (int i = 0; i < 400; i++) begin
      clr();
      bus.stall        = ($urandom_range(0, 7) == 0);
      bus.branch_taken = ($urandom_range(0, 3) == 0);
      bus.br_offset    = 16'($urandom);
      bus.jump         = ($urandom_range(0, 5) == 0);
      bus.jump_index   = 26'($urandom);
      bus.jreg         = ($urandom_range(0, 7) == 0);
      bus.jreg_target  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) bus.jreg_target[1:0] = 2'($urandom_range(1, 3));
      bus.call         = ($urandom_range(0, 3) == 0);
      bus.ret          = ($urandom_range(0, 4) == 0);
      step();
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
